// File: rtl/x_usr_access_seq.sv
// User-access configuration word bank: presents DEPTH preloaded words one at a time on DATA,
// stepping on ADVANCE in lockstep with the rising edge of a divided configuration clock.
module x_usr_access_seq #(
    parameter int                          DATA_WIDTH     = 32,
    parameter int                          DEPTH          = 4,
    parameter logic [DEPTH*DATA_WIDTH-1:0] INIT           = '0,
    parameter int                          CLK_DIV        = 4,
    parameter int                          STARTUP_CYCLES = 16,
    parameter string                       MODE           = "CYCLE",
    parameter string                       LOC            = "UNPLACED",
    localparam int                         IW             = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  ADVANCE,
    output logic                  CFGCLK,
    output logic [DATA_WIDTH-1:0] DATA,
    output logic                  DATAVALID,
    output logic [IW-1:0]         INDEX,
    output logic                  DONE
);

    localparam int            DW         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int            SW         = (STARTUP_CYCLES > 0) ? $clog2(STARTUP_CYCLES + 1) : 1;
    localparam bit            IS_STATIC  = (MODE == "STATIC");
    localparam bit            IS_ONESHOT = (MODE == "ONESHOT");
    localparam logic [IW-1:0] LAST       = IW'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_STARTUP,
        S_VALID,
        S_DROP,
        S_SETTLE,
        S_DONE
    } state_t;

    state_t        state;
    logic [DW-1:0] div_cnt;
    logic [SW-1:0] st_cnt;
    logic          div_tc;
    logic          rise;
    logic          st_done;
    logic [IW-1:0] nxt_idx;

    assign div_tc  = (div_cnt == DW'(CLK_DIV - 1));
    assign rise    = div_tc && !CFGCLK;
    assign st_done = (st_cnt == SW'(STARTUP_CYCLES));
    assign nxt_idx = (INDEX == LAST) ? '0 : INDEX + 1'b1;

    function automatic logic [DATA_WIDTH-1:0] word(input logic [IW-1:0] k);
        return INIT[int'(k)*DATA_WIDTH +: DATA_WIDTH];
    endfunction

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= S_STARTUP;
            div_cnt   <= '0;
            st_cnt    <= '0;
            CFGCLK    <= 1'b0;
            DATA      <= '0;
            DATAVALID <= 1'b0;
            INDEX     <= '0;
            DONE      <= 1'b0;
        end else begin
            if (div_tc) begin
                div_cnt <= '0;
                CFGCLK  <= ~CFGCLK;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
            // saturates, so st_done means "at least STARTUP_CYCLES edges already seen"
            if (!st_done)
                st_cnt <= st_cnt + 1'b1;

            case (state)
                S_STARTUP: begin
                    if (st_done && rise) begin
                        DATA      <= word('0);
                        INDEX     <= '0;
                        DATAVALID <= 1'b1;
                        state     <= S_VALID;
                    end
                end
                S_VALID: begin
                    if (ADVANCE && !IS_STATIC) begin
                        if (IS_ONESHOT && INDEX == LAST) begin
                            DONE  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            state <= S_DROP;
                        end
                    end
                end
                // the valid-drop edge is never also the load edge, so DATAVALID is always seen low
                S_DROP: begin
                    DATAVALID <= 1'b0;
                    state     <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (rise) begin
                        DATA      <= word(nxt_idx);
                        INDEX     <= nxt_idx;
                        DATAVALID <= 1'b1;
                        state     <= S_VALID;
                    end
                end
                S_DONE:  ;
                default: state <= S_STARTUP;
            endcase
        end
    end

endmodule
